// File: rtl/conv_window_buffer_pkg.sv
// Shared CNN definitions for the sliding-window buffer.
// Provides the frame FSM state encoding and the counter-width helper.
// No ports; imported by the window buffer and its line delays.
package conv_window_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Bits needed to hold any count in 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/conv_window_buffer_if.sv
// Pixel stream in / window stream out for the convolution window buffer.
// master: pixel source and window consumer; slave: the window buffer.
// i_valid/i_data carry raster pixels, o_window/o_valid/o_frame_done the windows.
interface conv_window_buffer_if #(
  parameter int WIDTH = 8,
  parameter int KSIZE = 5
);

  logic                             i_valid;
  logic signed [WIDTH-1:0]          i_data;
  logic [KSIZE*KSIZE*WIDTH-1:0]     o_window;
  logic                             o_valid;
  logic                             o_frame_done;

  modport master (
    output i_valid, i_data,
    input  o_window, o_valid, o_frame_done
  );

  modport slave (
    input  i_valid, i_data,
    output o_window, o_valid, o_frame_done
  );

endinterface

// File: rtl/line_delay.sv
// Runtime-length pixel delay line: dout is the sample written len enables ago.
// Ports: clk, global_rst_n (async), clr (sync), ce, len, din -> dout.
// Read is combinational from the current pointer; write and advance on ce.
module line_delay
  import conv_window_buffer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_COLS = 32
) (
  input  logic                              clk,
  input  logic                              global_rst_n,
  input  logic                              clr,
  input  logic                              ce,
  input  logic [$clog2(MAX_COLS+1)-1:0]     len,
  input  logic signed [WIDTH-1:0]           din,
  output logic signed [WIDTH-1:0]           dout
);

  localparam int LW = cnt_width(MAX_COLS);
  localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

  logic signed [WIDTH-1:0] mem [MAX_COLS];
  logic [AW-1:0]           ptr;

  // The slot about to be overwritten holds the sample from exactly len
  // accepted pixels ago, so it is the delayed output.
  assign dout = mem[ptr];

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      ptr <= '0;
      for (int i = 0; i < MAX_COLS; i++) mem[i] <= '0;
    end else if (clr) begin
      ptr <= '0;
      for (int i = 0; i < MAX_COLS; i++) mem[i] <= '0;
    end else if (ce) begin
      mem[ptr] <= din;
      ptr      <= (LW'(ptr) == len - LW'(1)) ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/conv_window_buffer.sv
// KSIZE x KSIZE sliding window over a raster pixel stream, runtime frame size.
// Ports: clk, global_rst_n (async), rst (sync), i_start/cfg_cols/cfg_rows,
// o_cfg_err, and the pixel/window stream on bus (slave). Latency 1 cycle.
module conv_window_buffer
  import conv_window_buffer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int KSIZE    = 5,
  parameter int MAX_COLS = 32
) (
  input  logic                          clk,
  input  logic                          global_rst_n,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [$clog2(MAX_COLS+1)-1:0] cfg_cols,
  input  logic [$clog2(MAX_COLS+1)-1:0] cfg_rows,
  output logic                          o_cfg_err,
  conv_window_buffer_if.slave           bus
);

  localparam int CW = cnt_width(MAX_COLS);

  state_t              state;
  logic [CW-1:0]       cols_q, rows_q;
  logic [CW-1:0]       col, row;
  logic                valid_q, done_q, cfg_err_q;
  logic                cfg_legal, start_ok, accept;
  logic                last_col, last_row;

  logic signed [WIDTH-1:0] tap [KSIZE];
  logic signed [WIDTH-1:0] win [KSIZE][KSIZE];
  logic [KSIZE*KSIZE*WIDTH-1:0] win_flat;

  assign cfg_legal = (cfg_cols >= CW'(KSIZE)) && (cfg_cols <= CW'(MAX_COLS)) &&
                     (cfg_rows >= CW'(KSIZE)) && (cfg_rows <= CW'(MAX_COLS));
  assign start_ok  = (state == ST_IDLE) && i_start && cfg_legal;
  assign accept    = (state == ST_ACTIVE) && bus.i_valid;
  assign last_col  = (col == cols_q - CW'(1));
  assign last_row  = (row == rows_q - CW'(1));

  // Frame FSM, pixel counters and registered status outputs.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state     <= ST_IDLE;
      cols_q    <= '0;
      rows_q    <= '0;
      col       <= '0;
      row       <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else if (rst) begin
      state     <= ST_IDLE;
      cols_q    <= '0;
      rows_q    <= '0;
      col       <= '0;
      row       <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            if (cfg_legal) begin
              cols_q    <= cfg_cols;
              rows_q    <= cfg_rows;
              col       <= '0;
              row       <= '0;
              cfg_err_q <= 1'b0;
              state     <= ST_ACTIVE;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (bus.i_valid) begin
            // Window is in-bounds once enough rows and columns are buffered.
            valid_q <= (row >= CW'(KSIZE-1)) && (col >= CW'(KSIZE-1));
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                done_q <= 1'b1;
                state  <= ST_DONE;
              end else begin
                row <= row + CW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // tap[k] is the pixel k rows above the current one; tap[0] is live input.
  assign tap[0] = bus.i_data;

  for (genvar k = 1; k < KSIZE; k++) begin : g_lines
    line_delay #(
      .WIDTH    (WIDTH),
      .MAX_COLS (MAX_COLS)
    ) u_line (
      .clk          (clk),
      .global_rst_n (global_rst_n),
      .clr          (rst || start_ok),
      .ce           (accept && !rst),
      .len          (cols_q),
      .din          (tap[k-1]),
      .dout         (tap[k])
    );
  end

  // Window shifts left on every accepted pixel; column KSIZE-1 takes the taps,
  // row 0 (oldest) from the deepest line delay.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++) win[r][c] <= '0;
    end else if (rst) begin
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++) win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE-1; c++) win[r][c] <= win[r][c+1];
        win[r][KSIZE-1] <= tap[KSIZE-1-r];
      end
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < KSIZE; r++)
      for (int c = 0; c < KSIZE; c++)
        win_flat[(r*KSIZE+c)*WIDTH +: WIDTH] = win[r][c];
  end

  assign bus.o_window     = win_flat;
  assign bus.o_valid      = valid_q;
  assign bus.o_frame_done = done_q;
  assign o_cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer with KSIZE=3 on 6x6 frames.
// Covers continuous/stalled frames, illegal config, sync clear, async reset,
// and negative pixel data against hand-computed windows.
module tb_conv_window_buffer;

  localparam int W  = 8;
  localparam int K  = 3;
  localparam int MC = 32;
  localparam int CW = $clog2(MC+1);
  localparam int WW = K*K*W;

  logic          clk = 1'b0;
  logic          global_rst_n;
  logic          rst;
  logic          i_start;
  logic [CW-1:0] cfg_cols, cfg_rows;
  logic          o_cfg_err;

  conv_window_buffer_if #(.WIDTH(W), .KSIZE(K)) bus ();

  conv_window_buffer #(
    .WIDTH    (W),
    .KSIZE    (K),
    .MAX_COLS (MC)
  ) dut (
    .clk          (clk),
    .global_rst_n (global_rst_n),
    .rst          (rst),
    .i_start      (i_start),
    .cfg_cols     (cfg_cols),
    .cfg_rows     (cfg_rows),
    .o_cfg_err    (o_cfg_err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Window for pixel (row,col) of a 6-wide frame whose pixel idx holds base+idx.
  function automatic logic [WW-1:0] exp_win(input int base, input int row, input int col);
    logic [WW-1:0] w;
    logic [W-1:0]  px;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        px = W'(base + (row-2+r)*6 + (col-2+c));
        w[(r*K+c)*W +: W] = px;
      end
    return w;
  endfunction

  function automatic logic [WW-1:0] pack9(input int v [9]);
    logic [WW-1:0] w;
    logic [W-1:0]  px;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      px = W'(v[k]);
      w[k*W +: W] = px;
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int base, input bit stall, input int npix,
                           output logic [WW-1:0] first_w, output logic [WW-1:0] last_w,
                           output int nvalid);
    cfg_cols = CW'(6);
    cfg_rows = CW'(6);
    i_start  = 1'b1;
    bus.i_valid = 1'b0;
    tick();
    i_start = 1'b0;
    check("cfg_err_after_start", o_cfg_err, 1'b0);
    nvalid  = 0;
    first_w = '0;
    last_w  = '0;
    for (int idx = 0; idx < npix; idx++) begin
      int   row, col;
      logic ev;
      row = idx / 6;
      col = idx % 6;
      ev  = (row >= 2) && (col >= 2);
      bus.i_valid = 1'b1;
      bus.i_data  = W'(base + idx);
      tick();
      bus.i_valid = 1'b0;
      check("o_valid", bus.o_valid, ev);
      check("o_frame_done", bus.o_frame_done, idx == 35);
      if (ev) begin
        check("o_window", bus.o_window, exp_win(base, row, col));
        if (nvalid == 0) first_w = bus.o_window;
        last_w = bus.o_window;
        nvalid++;
      end
      if (stall) begin
        tick();
        check("stall_valid", bus.o_valid, 1'b0);
        if (ev) check("stall_hold", bus.o_window, exp_win(base, row, col));
      end
    end
  endtask

  logic [WW-1:0] fw, lw;
  int            nv;
  int            cnt;
  int            a_first [9];
  int            a_last  [9];
  int            n_first [9];
  int            n_last  [9];

  task automatic check_frame(input string tag, input logic [WW-1:0] f, input logic [WW-1:0] l,
                             input int n, input logic [WW-1:0] ef, input logic [WW-1:0] el);
    check({tag, "_first"}, f, ef);
    check({tag, "_last"}, l, el);
    check({tag, "_count"}, WW'(n), WW'(16));
    tick();
    check({tag, "_post_valid"}, bus.o_valid, 1'b0);
    check({tag, "_post_done"}, bus.o_frame_done, 1'b0);
  endtask

  initial begin
    a_first = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
    a_last  = '{21, 22, 23, 27, 28, 29, 33, 34, 35};
    for (int k = 0; k < 9; k++) begin
      n_first[k] = a_first[k] - 128;
      n_last[k]  = a_last[k] - 128;
    end

    global_rst_n = 1'b0;
    rst          = 1'b0;
    i_start      = 1'b0;
    cfg_cols     = '0;
    cfg_rows     = '0;
    bus.i_valid  = 1'b0;
    bus.i_data   = '0;
    tick();
    tick();
    check("reset_window", bus.o_window, '0);
    check("reset_valid", bus.o_valid, 1'b0);
    check("reset_done", bus.o_frame_done, 1'b0);
    check("reset_cfg_err", o_cfg_err, 1'b0);
    global_rst_n = 1'b1;
    tick();

    // Continuous 6x6 frame.
    run_frame(0, 1'b0, 36, fw, lw, nv);
    check_frame("cont", fw, lw, nv, pack9(a_first), pack9(a_last));

    // Same frame with a stall after every pixel.
    run_frame(0, 1'b1, 36, fw, lw, nv);
    check_frame("stall", fw, lw, nv, pack9(a_first), pack9(a_last));

    // Illegal config: too few columns.
    cfg_cols = CW'(2);
    cfg_rows = CW'(6);
    i_start  = 1'b1;
    tick();
    i_start = 1'b0;
    check("cfg_err_set", o_cfg_err, 1'b1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = W'(i);
      tick();
      if (bus.o_valid) cnt++;
    end
    bus.i_valid = 1'b0;
    check("cfg_err_no_valid", WW'(cnt), WW'(0));
    check("cfg_err_sticky", o_cfg_err, 1'b1);
    run_frame(0, 1'b0, 36, fw, lw, nv);
    check_frame("after_err", fw, lw, nv, pack9(a_first), pack9(a_last));

    // Synchronous clear after pixel 20, with a pixel offered in the same cycle.
    run_frame(0, 1'b0, 21, fw, lw, nv);
    rst         = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = W'(99);
    tick();
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    check("rst_window", bus.o_window, '0);
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_done", bus.o_frame_done, 1'b0);
    check("rst_cfg_err", o_cfg_err, 1'b0);
    run_frame(0, 1'b0, 36, fw, lw, nv);
    check_frame("after_rst", fw, lw, nv, pack9(a_first), pack9(a_last));

    // Asynchronous reset mid-frame.
    run_frame(0, 1'b0, 20, fw, lw, nv);
    #3;
    global_rst_n = 1'b0;
    #1;
    check("arst_window", bus.o_window, '0);
    check("arst_valid", bus.o_valid, 1'b0);
    check("arst_done", bus.o_frame_done, 1'b0);
    check("arst_cfg_err", o_cfg_err, 1'b0);
    tick();
    global_rst_n = 1'b1;
    // Without a fresh start the FSM stays idle and pixels are ignored.
    cnt = 0;
    for (int i = 0; i < 36; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = W'(i);
      tick();
      if (bus.o_valid || bus.o_frame_done) cnt++;
    end
    bus.i_valid = 1'b0;
    check("arst_idle", WW'(cnt), WW'(0));

    // Negative pixels -128..-93.
    run_frame(-128, 1'b0, 36, fw, lw, nv);
    check_frame("neg", fw, lw, nv, pack9(n_first), pack9(n_last));
    check("neg_first_px", WW'($signed(fw[W-1:0])), WW'(-128));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_buffer.md
CONV_WINDOW_BUFFER -- requirements
Module: conv_window_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning signed pixel width in bits.
REQ-002 SHALL have parameter KSIZE, default 5, meaning window side length (KSIZE x KSIZE taps).
REQ-003 SHALL have parameter MAX_COLS, default 32, meaning maximum supported feature-map row length.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port global_rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port rst, input, 1, meaning synchronous clear, active-high.
REQ-007 SHALL have port i_start, input, 1, meaning a one-cycle pulse that latches cfg_cols/cfg_rows and begins a frame.
REQ-008 SHALL have port cfg_cols, input, $clog2(MAX_COLS+1), meaning runtime row length.
REQ-009 SHALL have port cfg_rows, input, $clog2(MAX_COLS+1), meaning runtime row count.
REQ-010 SHALL have port i_valid, input, 1, meaning i_data is accepted this cycle (clock enable).
REQ-011 SHALL have port i_data, input, WIDTH signed, meaning pixel data in raster order.
REQ-012 SHALL have port o_window, output, KSIZE*KSIZE*WIDTH, meaning the window, with element (r,c) at bits [(r*KSIZE+c)*WIDTH +: WIDTH]; r=0 is the oldest row, c=0 the oldest column.
REQ-013 SHALL have port o_valid, output, 1, meaning o_window holds a complete, in-bounds window.
REQ-014 SHALL have port o_frame_done, output, 1, meaning a one-cycle pulse after the last frame pixel.
REQ-015 SHALL have port o_cfg_err, output, 1, meaning a sticky flag for an illegal configuration.

Function
REQ-016 SHALL implement FSM IDLE -> ACTIVE on i_start with legal config; ACTIVE -> DONE on acceptance of pixel (cfg_rows-1, cfg_cols-1); DONE -> IDLE after one cycle.
REQ-017 SHALL treat a config as legal iff KSIZE <= cfg_cols <= MAX_COLS and KSIZE <= cfg_rows <= MAX_COLS; an illegal i_start sets o_cfg_err and leaves the FSM in IDLE.
REQ-018 SHALL ignore i_valid outside ACTIVE; in ACTIVE, each i_valid advances the column counter, which wraps at cfg_cols-1 and then increments the row counter.
REQ-019 SHALL hold KSIZE-1 line delays of runtime length cfg_cols plus a KSIZE x KSIZE window register array; all shift only on accepted pixels.
REQ-020 SHALL assert o_valid the cycle after accepting pixel (row,col) iff row >= KSIZE-1 and col >= KSIZE-1; latency is 1 cycle.
REQ-021 SHALL deassert o_valid on any cycle without an accepted pixel; o_window holds its value in that case.
REQ-022 SHALL pulse o_frame_done in the DONE cycle, coincident with the final o_valid.
REQ-023 SHALL ignore i_start while ACTIVE.
REQ-024 SHALL, on rst, return to IDLE and zero the counters, delays, window, o_valid, o_frame_done and o_cfg_err; rst has priority over i_start and i_valid in the same cycle.
REQ-025 SHALL clear o_cfg_err only on a subsequent legal i_start or on reset.
REQ-026 SHALL pass data unchanged; no arithmetic, sign preserved.

Reset
REQ-027 SHALL, on global_rst_n low, immediately force the FSM to IDLE, all storage to 0, o_window to 0, and o_valid/o_frame_done/o_cfg_err to 0.
REQ-028 SHALL, on global_rst_n low mid-frame, discard all data; the next frame requires a fresh i_start.

Structure
REQ-029 SHALL take the FSM state encoding and the counter-width function from the shared cnn package.
REQ-030 SHALL use one sub-module, line_delay (WIDTH, MAX_COLS, runtime length input, ce, sync clear), instantiated KSIZE-1 times.

Verification
REQ-031 SHALL cover: KSIZE=3, cfg 6x6, pixels 0..35 continuous -> first o_valid after pixel 14 with window {0,1,2,6,7,8,12,13,14}, 16 valid windows, o_frame_done with the last window {21,22,23,27,28,29,33,34,35}.
REQ-032 SHALL cover: the same frame with i_valid low every other cycle -> identical window sequence, o_valid never asserted on stall cycles.
REQ-033 SHALL cover: i_start with cfg_cols=2 -> o_cfg_err=1, FSM stays IDLE, no o_valid; then a legal i_start -> o_cfg_err=0.
REQ-034 SHALL cover: rst asserted after pixel 20 -> next cycle all outputs 0; a new 6x6 frame reproduces REQ-031 exactly.
REQ-035 SHALL cover: global_rst_n pulsed low mid-frame -> outputs 0 asynchronously, state IDLE.
REQ-036 SHALL cover: negative data (-128..-93) in a 6x6 frame -> window values sign-exact.
